// File: rtl/flash_playback_controller.sv
// flash_playback_controller
//   Sequences the flash audio reader: owns the flash word address and the
//   play/pause state, generates the per-sample start strobe from a
//   programmable divider, and applies direction and wrap-around to the
//   reader's address step/restart requests.
//
// Ports
//   clk, rst             system clock, asynchronous active-low reset
//   cmd_play/cmd_pause   1-cycle pulses selecting PLAY / PAUSE (pause wins)
//   cmd_forward/backward 1-cycle pulses selecting play direction
//   cmd_restart          jump to region start for the current direction,
//                        also clears sample_overrun
//   speed_up/down/reset  divider -= step / += step / = default
//   address_inc/dec/rst  step requests from the flash reader
//   reader_busy          reader is mid-sample
//   startsamplenow       1-cycle sample-start strobe to the reader
//   flsh_address         current flash word address
//   playing, direction   play state (1 = PLAY), direction (1 = backward)
//   divider              current clk cycles per sample
//   sample_overrun       sticky: strobe issued while reader was busy
module flash_playback_controller #(
  parameter int unsigned        ADDR_W      = 23,
  parameter logic [ADDR_W-1:0]  START_ADDR  = 23'h000000,
  parameter logic [ADDR_W-1:0]  END_ADDR    = 23'h07FFFF,
  parameter int unsigned        DIV_W       = 16,
  parameter int unsigned        DEFAULT_DIV = 2272,
  parameter int unsigned        DIV_STEP    = 64,
  parameter int unsigned        DIV_MIN     = 256,
  parameter int unsigned        DIV_MAX     = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_play,
  input  logic              cmd_pause,
  input  logic              cmd_forward,
  input  logic              cmd_backward,
  input  logic              cmd_restart,
  input  logic              speed_up,
  input  logic              speed_down,
  input  logic              speed_reset,
  input  logic              address_inc,
  input  logic              address_dec,
  input  logic              address_rst,
  input  logic              reader_busy,
  output logic              startsamplenow,
  output logic [ADDR_W-1:0] flsh_address,
  output logic              playing,
  output logic              direction,
  output logic [DIV_W-1:0]  divider,
  output logic              sample_overrun
);

  localparam int unsigned DW1 = DIV_W + 1;

  localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(DEFAULT_DIV);
  localparam logic [DW1-1:0]   STEP_X  = DW1'(DIV_STEP);
  localparam logic [DW1-1:0]   MIN_X   = DW1'(DIV_MIN);
  localparam logic [DW1-1:0]   MAX_X   = DW1'(DIV_MAX);

  typedef enum logic {
    PAUSE = 1'b0,
    PLAY  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              strobe_q, strobe_d;
  logic              ovr_q, ovr_d;

  logic [DW1-1:0]    div_wide;
  logic              step_up;
  logic              step_down;

  // ---------------------------------------------------------------------
  // Play/pause state machine
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PAUSE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cmd_pause) begin
      state_d = PAUSE;
    end else if (cmd_play) begin
      state_d = PLAY;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    div_d    = div_q;
    div_wide = '0;
    dir_d    = dir_q;
    addr_d   = addr_q;
    ovr_d    = ovr_q;
    step_up   = 1'b0;
    step_down = 1'b0;

    // Tick counter: ">=" rather than "==" so that a divider reduction
    // below the current count wraps immediately instead of counting
    // all the way round.
    if (state_q == PLAY) begin
      if (({1'b0, cnt_q} + DW1'(1)) >= {1'b0, div_q}) begin
        cnt_d    = '0;
        strobe_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    // Divider with saturation, evaluated one bit wider to avoid wrap.
    if (speed_reset) begin
      div_d = DIV_DEF;
    end else if (speed_up) begin
      if ({1'b0, div_q} < (MIN_X + STEP_X)) begin
        div_d = DIV_W'(DIV_MIN);
      end else begin
        div_wide = {1'b0, div_q} - STEP_X;
        div_d    = div_wide[DIV_W-1:0];
      end
    end else if (speed_down) begin
      div_wide = {1'b0, div_q} + STEP_X;
      if (div_wide > MAX_X) begin
        div_d = DIV_W'(DIV_MAX);
      end else begin
        div_d = div_wide[DIV_W-1:0];
      end
    end

    if (cmd_forward && !cmd_backward) begin
      dir_d = 1'b0;
    end else if (cmd_backward && !cmd_forward) begin
      dir_d = 1'b1;
    end

    // Address: inc/dec are relative to play direction, so map them to
    // absolute +1/-1 using the currently registered direction.
    if (cmd_restart || address_rst) begin
      addr_d = dir_q ? END_ADDR : START_ADDR;
    end else if (address_inc && address_dec) begin
      addr_d = addr_q;
    end else begin
      step_up   = (address_inc && !dir_q) || (address_dec && dir_q);
      step_down = (address_inc && dir_q)  || (address_dec && !dir_q);
      if (step_up) begin
        addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
      end else if (step_down) begin
        addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_W'(1);
      end
    end

    // Restart clears the sticky flag even if an overrun coincides.
    if (cmd_restart) begin
      ovr_d = 1'b0;
    end else if (strobe_q && reader_busy) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      div_q    <= DIV_DEF;
      dir_q    <= 1'b0;
      addr_q   <= START_ADDR;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      div_q    <= div_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign startsamplenow = strobe_q;
  assign flsh_address   = addr_q;
  assign playing        = (state_q == PLAY);
  assign direction      = dir_q;
  assign divider        = div_q;
  assign sample_overrun = ovr_q;

endmodule

// File: tb/tb_flash_playback_controller.sv
// Testbench for flash_playback_controller with a reduced configuration
// (4-word region 0x10..0x13, divider 2..6, step 1, default 4).
module tb_flash_playback_controller;

  localparam int START = 16;
  localparam int END_A = 19;
  localparam int NWORD = END_A - START + 1;
  localparam int DDEF  = 4;
  localparam int DMIN  = 2;
  localparam int DMAX  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_play = 1'b0, cmd_pause = 1'b0;
  logic        cmd_forward = 1'b0, cmd_backward = 1'b0, cmd_restart = 1'b0;
  logic        speed_up = 1'b0, speed_down = 1'b0, speed_reset = 1'b0;
  logic        address_inc = 1'b0, address_dec = 1'b0, address_rst = 1'b0;
  logic        reader_busy = 1'b0;
  logic        startsamplenow;
  logic [22:0] flsh_address;
  logic        playing;
  logic        direction;
  logic [15:0] divider;
  logic        sample_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_play, m_cnt, m_div, m_dir, m_addr, m_strobe, m_ovr;

  flash_playback_controller #(
    .ADDR_W(23), .START_ADDR(23'h10), .END_ADDR(23'h13),
    .DIV_W(16), .DEFAULT_DIV(4), .DIV_STEP(1), .DIV_MIN(2), .DIV_MAX(6)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_play(cmd_play), .cmd_pause(cmd_pause),
    .cmd_forward(cmd_forward), .cmd_backward(cmd_backward),
    .cmd_restart(cmd_restart),
    .speed_up(speed_up), .speed_down(speed_down), .speed_reset(speed_reset),
    .address_inc(address_inc), .address_dec(address_dec),
    .address_rst(address_rst), .reader_busy(reader_busy),
    .startsamplenow(startsamplenow), .flsh_address(flsh_address),
    .playing(playing), .direction(direction), .divider(divider),
    .sample_overrun(sample_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_play = 0; m_cnt = 0; m_div = DDEF; m_dir = 0;
    m_addr = START; m_strobe = 0; m_ovr = 0;
  endtask

  // One clock of the reference behaviour, from the rules in plain arithmetic.
  task automatic model_step();
    int n_play, n_cnt, n_div, n_dir, n_addr, n_strobe, n_ovr, delta;
    n_strobe = (m_play != 0 && m_cnt >= m_div - 1) ? 1 : 0;
    n_cnt    = (m_play == 0) ? m_cnt : (n_strobe != 0 ? 0 : m_cnt + 1);
    n_ovr    = cmd_restart ? 0 : ((m_strobe != 0 && reader_busy) ? 1 : m_ovr);
    n_play   = cmd_pause ? 0 : (cmd_play ? 1 : m_play);
    if (speed_reset)     n_div = DDEF;
    else if (speed_up)   n_div = (m_div - 1 < DMIN) ? DMIN : m_div - 1;
    else if (speed_down) n_div = (m_div + 1 > DMAX) ? DMAX : m_div + 1;
    else                 n_div = m_div;
    n_dir = (cmd_forward && !cmd_backward) ? 0 :
            (cmd_backward && !cmd_forward) ? 1 : m_dir;
    if (cmd_restart || address_rst) begin
      n_addr = (m_dir != 0) ? END_A : START;
    end else begin
      delta = 0;
      if (address_inc && !address_dec)      delta = (m_dir != 0) ? -1 : 1;
      else if (address_dec && !address_inc) delta = (m_dir != 0) ? 1 : -1;
      n_addr = START + ((m_addr - START + delta + NWORD) % NWORD);
    end
    m_play = n_play; m_cnt = n_cnt; m_div = n_div; m_dir = n_dir;
    m_addr = n_addr; m_strobe = n_strobe; m_ovr = n_ovr;
  endtask

  task automatic compare_all();
    check("strobe",  32'(startsamplenow), 32'(m_strobe));
    check("address", 32'(flsh_address),   32'(m_addr));
    check("playing", 32'(playing),        32'(m_play));
    check("dir",     32'(direction),      32'(m_dir));
    check("divider", 32'(divider),        32'(m_div));
    check("overrun", 32'(sample_overrun), 32'(m_ovr));
  endtask

  task automatic clear_pulses();
    cmd_play = 0; cmd_pause = 0; cmd_forward = 0; cmd_backward = 0;
    cmd_restart = 0; speed_up = 0; speed_down = 0; speed_reset = 0;
    address_inc = 0; address_dec = 0; address_rst = 0;
  endtask

  // Called at a falling edge with inputs already set; returns at the next
  // falling edge with pulses cleared.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int prev;
    int guard;
    model_reset();
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobe",  32'(startsamplenow), 32'd0);
    check("rst_addr",    32'(flsh_address),   32'h10);
    check("rst_playing", 32'(playing),        32'd0);
    check("rst_div",     32'(divider),        32'd4);
    check("rst_ovr",     32'(sample_overrun), 32'd0);
    rst = 1'b1;
    idle(2);

    // 1: play, strobe every 4 clocks starting 4 after the play cycle
    cmd_play = 1; cycle();
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check("t1_strobe", 32'(startsamplenow), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    check("t1_playing", 32'(playing), 32'd1);

    // 2: forward stepping with wrap, then backward
    address_inc = 1; cycle(); check("t2_a0", 32'(flsh_address), 32'h11);
    address_inc = 1; cycle(); check("t2_a1", 32'(flsh_address), 32'h12);
    address_inc = 1; cycle(); check("t2_a2", 32'(flsh_address), 32'h13);
    address_inc = 1; cycle(); check("t2_a3", 32'(flsh_address), 32'h10);
    cmd_backward = 1; cycle();
    address_inc = 1; cycle(); check("t2_back", 32'(flsh_address), 32'h13);

    // 3: pause with count held, resume continues the count
    guard = 0;
    while (m_cnt != 0 && guard < 16) begin cycle(); guard++; end
    check("t3_sync", 32'(m_cnt), 32'd0);
    cycle();
    cmd_pause = 1; cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t3_paused_strobe", 32'(startsamplenow), 32'd0);
    end
    cmd_play = 1; cycle();
    cycle(); check("t3_resume1", 32'(startsamplenow), 32'd0);
    cycle(); check("t3_resume2", 32'(startsamplenow), 32'd1);

    // 4: divider saturation and priority
    speed_up = 1; cycle(); check("t4_d3", 32'(divider), 32'd3); idle(7);
    speed_up = 1; cycle(); check("t4_d2", 32'(divider), 32'd2); idle(6);
    speed_up = 1; cycle(); check("t4_sat", 32'(divider), 32'd2); idle(5);
    speed_down = 1; speed_reset = 1; cycle();
    check("t4_reset", 32'(divider), 32'd4); idle(9);
    speed_down = 1; cycle(); speed_down = 1; cycle(); speed_down = 1; cycle();
    check("t4_max", 32'(divider), 32'd6); idle(13);
    speed_reset = 1; cycle();

    // 5: overrun is sticky until restart
    reader_busy = 1; idle(8); reader_busy = 0;
    check("t5_ovr_set", 32'(sample_overrun), 32'd1);
    idle(6);
    check("t5_ovr_hold", 32'(sample_overrun), 32'd1);
    cmd_backward = 1; cycle();
    cmd_restart = 1; cycle();
    check("t5_ovr_clr", 32'(sample_overrun), 32'd0);
    check("t5_restart_addr", 32'(flsh_address), 32'h13);

    // 6: conflicting requests, restart priority, async reset
    address_dec = 1; cycle(); prev = m_addr;
    address_inc = 1; address_dec = 1; cycle();
    check("t6_incdec", 32'(flsh_address), 32'(prev));
    address_rst = 1; address_inc = 1; cycle();
    check("t6_rst_back", 32'(flsh_address), 32'h13);
    cmd_forward = 1; cycle();
    address_dec = 1; cycle();
    address_rst = 1; address_inc = 1; cycle();
    check("t6_rst_fwd", 32'(flsh_address), 32'h10);
    idle(2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    check("t6_rst_hold_strobe", 32'(startsamplenow), 32'd0);
    @(negedge clk); rst = 1'b1;
    cycle();
    check("t6_release_strobe", 32'(startsamplenow), 32'd0);

    // Random phase against the model
    for (int i = 0; i < 600; i++) begin
      cmd_play     = ($urandom_range(5) == 0);
      cmd_pause    = ($urandom_range(19) == 0);
      cmd_forward  = ($urandom_range(9) == 0);
      cmd_backward = ($urandom_range(9) == 0);
      cmd_restart  = ($urandom_range(29) == 0);
      speed_up     = ($urandom_range(11) == 0);
      speed_down   = ($urandom_range(11) == 0);
      speed_reset  = ($urandom_range(39) == 0);
      address_inc  = ($urandom_range(3) == 0);
      address_dec  = ($urandom_range(7) == 0);
      address_rst  = ($urandom_range(29) == 0);
      reader_busy  = ($urandom_range(3) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_playback_controller.md
Name: flash_playback_controller

Overview:
- Sequences the flash audio reader. Owns the flash word-address register and the play/pause state.
- Generates the per-sample start strobe (startsamplenow) from a programmable divider.
- Applies direction and wrap-around to the reader's address_inc/address_dec/address_rst requests.
- Sits between keyboard/command decode and the flash reader; the reader's flash read address comes from flsh_address here.

Parameters:
ADDR_W, 23, flash word-address width
START_ADDR, 23'h000000, first word of audio region
END_ADDR, 23'h07FFFF, last word of audio region (END_ADDR > START_ADDR)
DIV_W, 16, sample-divider width
DEFAULT_DIV, 2272, clk cycles per sample at reset (50 MHz / ~22 kHz)
DIV_STEP, 64, divider change per speed_up/speed_down
DIV_MIN, 256, fastest allowed divider
DIV_MAX, 8192, slowest allowed divider

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_play  in  1  1-cycle pulse: enter PLAY
cmd_pause  in  1  1-cycle pulse: enter PAUSE
cmd_forward  in  1  1-cycle pulse: direction = forward
cmd_backward  in  1  1-cycle pulse: direction = backward
cmd_restart  in  1  1-cycle pulse: address to region start for current direction
speed_up  in  1  pulse: divider -= DIV_STEP
speed_down  in  1  pulse: divider += DIV_STEP
speed_reset  in  1  pulse: divider = DEFAULT_DIV
address_inc  in  1  from reader: advance one word in play direction
address_dec  in  1  from reader: step one word against play direction
address_rst  in  1  from reader: same effect as cmd_restart
reader_busy  in  1  reader mid-sample (not idle)
startsamplenow  out  1  1-cycle sample-start strobe to reader
flsh_address  out  ADDR_W  current flash word address
playing  out  1  1 in PLAY
direction  out  1  0 = forward, 1 = backward
divider  out  DIV_W  current divider value
sample_overrun  out  1  sticky: strobe issued while reader_busy

Behaviour:
- Reset (rst=0, async) values:
  - state = PAUSE, playing = 0, direction = 0
  - flsh_address = START_ADDR, divider = DEFAULT_DIV, tick counter = 0
  - startsamplenow = 0, sample_overrun = 0
- State machine, two states: PAUSE, PLAY.
  - cmd_play: PAUSE -> PLAY.
  - cmd_pause: PLAY -> PAUSE.
  - cmd_play and cmd_pause in the same cycle: pause wins.
  - Either command while already in the target state: no effect.
- Tick counter:
  - In PLAY it counts 0..divider-1. On the cycle the counter equals divider-1, the counter returns to 0 and startsamplenow is registered high for exactly the next cycle.
  - First strobe arrives divider cycles after the PLAY transition cycle.
  - In PAUSE the counter holds its value (no clear) and startsamplenow = 0. Resuming continues the count.
  - If a divider change leaves counter >= divider-1, the counter wraps to 0 and strobes next cycle (no long gap).
- Divider, registered update:
  - Priority: speed_reset > speed_up > speed_down.
  - speed_up: divider = max(divider-DIV_STEP, DIV_MIN).
  - speed_down: divider = min(divider+DIV_STEP, DIV_MAX).
  - Arithmetic is DIV_W+1 bits internally, then saturated; no wrap.
- Direction: cmd_forward sets 0, cmd_backward sets 1. If both arrive in the same cycle, no change. New direction applies to the next address update.
- Address update, single registered update per cycle, priority:
  1. Restart (cmd_restart or address_rst) -> START_ADDR if direction = 0, END_ADDR if direction = 1 (direction value in effect that cycle).
  2. address_inc and address_dec both high -> no change.
  3. address_inc: forward +1, backward -1.
  4. address_dec: forward -1, backward +1.
- Address wrap:
  - +1 at END_ADDR -> START_ADDR.
  - -1 at START_ADDR -> END_ADDR.
  - flsh_address never leaves [START_ADDR, END_ADDR].
- Address requests are honoured in both PLAY and PAUSE.
- sample_overrun: set when startsamplenow is asserted while reader_busy = 1. Cleared only by reset or cmd_restart.
- All outputs come directly from registers; no combinational input-to-output paths.
- Reset asserted mid-operation returns every register to its reset value immediately; no strobe is issued during or on the cycle of reset release.

Test Plan (bench overrides DEFAULT_DIV=4, DIV_MIN=2, DIV_STEP=1, DIV_MAX=6, START_ADDR=0x10, END_ADDR=0x13):
1. Release reset, pulse cmd_play -> startsamplenow 1-cycle pulses every 4 clks, first at 4 clks after the play cycle; playing=1, flsh_address=0x10.
2. Forward: address_inc x4 -> flsh_address 0x11, 0x12, 0x13, 0x10 (wrap). Then cmd_backward + address_inc -> 0x13.
3. cmd_pause after 2 counted cycles, wait 10, cmd_play -> next strobe 2 cycles after resume; no strobe while paused.
4. speed_up x3 -> divider 3, 2, 2 (saturated). Then speed_down + speed_reset same cycle -> divider 4. Strobe spacing follows each value.
5. reader_busy=1 across a strobe -> sample_overrun=1 and stays 1. Then cmd_restart with direction=1 -> sample_overrun=0, flsh_address=0x13.
6. Mid-play, address_inc & address_dec together -> address unchanged. Then address_rst & address_inc together -> START/END per direction. Async rst low mid-count -> all outputs at reset values, no strobe.
